// File: rtl/id_branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_branch_pkg
// Description : Shared types and helpers for the ID-stage branch resolve
//               control (FSM states, zero-register constant, compare helper).
// Revision    : 1.0 - initial release
// ============================================================================
package id_branch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        SHADOW = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         CNT_W_DEFAULT = 16;

    // Register 0 is hardwired, so it never produces a hazard or a forward.
    function automatic logic reg_match(input logic [4:0] x, input logic [4:0] y);
        return (y != REG_ZERO) && (x == y);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import id_branch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/id_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_branch_resolve_ctrl
// Description : ID-stage branch hazard stall, WB forward selects, beq/bne
//               resolution with IF/ID flush, perf counters and stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module id_branch_resolve_ctrl
    import id_branch_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int MAX_STALL = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Beq_ID,
    input  logic             Bne_ID,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             RegWrite_EX,
    input  logic [4:0]       Write_Reg_EX,
    input  logic             RegWrite_MEM,
    input  logic [4:0]       Write_Reg_MEM,
    input  logic             RegWrite_WB,
    input  logic [4:0]       Write_Reg_WB,
    input  logic             Comparetor_ID,
    input  logic             Flush_Ext,
    output logic             Forward_C_ID,
    output logic             Forward_D_ID,
    output logic             Stall_ID,
    output logic             PCSrc_ID,
    output logic             IF_Flush,
    output logic             Stall_Err_ID,
    output logic [CNT_W-1:0] Branch_Cnt,
    output logic [CNT_W-1:0] Taken_Cnt,
    output logic [CNT_W-1:0] Stall_Cnt
);

    localparam int                 c_RUN_W     = $clog2(MAX_STALL + 2);
    localparam logic [c_RUN_W-1:0] c_RUN_LIMIT = c_RUN_W'(MAX_STALL + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_is_br;
    logic               w_haz_ex;
    logic               w_haz_mem;
    logic               w_hazard;
    logic               w_taken;
    logic               w_stall;
    logic               w_resolve;
    logic [c_RUN_W-1:0] r_run;
    logic [c_RUN_W-1:0] w_run_nxt;
    logic               r_err;

    assign w_is_br   = Beq_ID | Bne_ID;
    assign w_haz_ex  = RegWrite_EX  & (reg_match(Rs_ID, Write_Reg_EX)  | reg_match(Rt_ID, Write_Reg_EX));
    assign w_haz_mem = RegWrite_MEM & (reg_match(Rs_ID, Write_Reg_MEM) | reg_match(Rt_ID, Write_Reg_MEM));
    assign w_hazard  = w_is_br & (w_haz_ex | w_haz_mem);
    assign w_taken   = Beq_ID ? Comparetor_ID : ~Comparetor_ID;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IDLE and STALL share the resolve rules; only SHADOW ignores the branch.
    always_comb begin
        w_state_nxt = IDLE;
        w_stall     = 1'b0;
        w_resolve   = 1'b0;
        case (r_state)
            IDLE, STALL: begin
                if (w_is_br) begin
                    if (w_hazard) begin
                        w_stall     = 1'b1;
                        w_state_nxt = STALL;
                    end else begin
                        w_resolve   = 1'b1;
                        w_state_nxt = w_taken ? SHADOW : IDLE;
                    end
                end
            end
            SHADOW:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (Flush_Ext || Reset) begin
            w_state_nxt = IDLE;
            w_stall     = 1'b0;
            w_resolve   = 1'b0;
        end
    end

    assign Stall_ID     = w_stall;
    assign PCSrc_ID     = w_resolve & w_taken;
    assign IF_Flush     = w_resolve & w_taken;
    assign Forward_C_ID = ~Reset & RegWrite_WB & reg_match(Rs_ID, Write_Reg_WB);
    assign Forward_D_ID = ~Reset & RegWrite_WB & reg_match(Rt_ID, Write_Reg_WB);

    // The run includes the IDLE cycle that first detects the hazard.
    always_comb begin
        w_run_nxt = '0;
        if (w_stall) begin
            w_run_nxt = (r_run == c_RUN_LIMIT) ? r_run : r_run + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_run <= '0;
            r_err <= 1'b0;
        end else begin
            r_run <= w_run_nxt;
            if (w_run_nxt == c_RUN_LIMIT) begin
                r_err <= 1'b1;
            end
        end
    end

    assign Stall_Err_ID = r_err;

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk     (Clk),
        .rst     (Reset),
        .i_inc   (w_resolve),
        .o_count (Branch_Cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk     (Clk),
        .rst     (Reset),
        .i_inc   (w_resolve & w_taken),
        .o_count (Taken_Cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (Clk),
        .rst     (Reset),
        .i_inc   (w_stall),
        .o_count (Stall_Cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_id_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_branch_resolve_ctrl
// Description : Directed-vector bench with an expected-value queue drained by
//               an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_branch_resolve_ctrl;

    localparam int c_CNT_W = 4;

    typedef struct packed {
        logic             fc;
        logic             fd;
        logic             st;
        logic             pc;
        logic             err;
        logic [c_CNT_W-1:0] b;
        logic [c_CNT_W-1:0] t;
        logic [c_CNT_W-1:0] s;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               beq, bne, rwex, rwmem, rwwb, cmp, flush;
    logic [4:0]         rs, rt, wex, wmem, wwb;
    logic               fc, fd, st, pc, ifl, err;
    logic [c_CNT_W-1:0] bcnt, tcnt, scnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    id_branch_resolve_ctrl #(.CNT_W(c_CNT_W), .MAX_STALL(3)) dut (
        .Clk           (clk),
        .Reset         (rst),
        .Beq_ID        (beq),
        .Bne_ID        (bne),
        .Rs_ID         (rs),
        .Rt_ID         (rt),
        .RegWrite_EX   (rwex),
        .Write_Reg_EX  (wex),
        .RegWrite_MEM  (rwmem),
        .Write_Reg_MEM (wmem),
        .RegWrite_WB   (rwwb),
        .Write_Reg_WB  (wwb),
        .Comparetor_ID (cmp),
        .Flush_Ext     (flush),
        .Forward_C_ID  (fc),
        .Forward_D_ID  (fd),
        .Stall_ID      (st),
        .PCSrc_ID      (pc),
        .IF_Flush      (ifl),
        .Stall_Err_ID  (err),
        .Branch_Cnt    (bcnt),
        .Taken_Cnt     (tcnt),
        .Stall_Cnt     (scnt)
    );

    function automatic exp_t mk(input logic efc, input logic efd, input logic est,
                                input logic epc, input logic eerr,
                                input logic [c_CNT_W-1:0] eb,
                                input logic [c_CNT_W-1:0] et,
                                input logic [c_CNT_W-1:0] es);
        exp_t e;
        e.fc = efc; e.fd = efd; e.st = est; e.pc = epc; e.err = eerr;
        e.b = eb; e.t = et; e.s = es;
        return e;
    endfunction

    // Drive one cycle of inputs, queue its expected outputs, advance a clock.
    task automatic vec(input string nm, input logic ibeq, input logic ibne,
                       input logic [4:0] irs, input logic [4:0] irt,
                       input logic irwex, input logic [4:0] iwex,
                       input logic irwmem, input logic [4:0] iwmem,
                       input logic irwwb, input logic [4:0] iwwb,
                       input logic icmp, input logic iflush, input logic irst,
                       input exp_t e);
        beq = ibeq; bne = ibne; rs = irs; rt = irt;
        rwex = irwex; wex = iwex; rwmem = irwmem; wmem = iwmem;
        rwwb = irwwb; wwb = iwwb; cmp = icmp; flush = iflush; rst = irst;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input exp_t e);
        vec(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic chk(input string nm, input string fld,
                       input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got=%0d want=%0d", nm, fld, act, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "fwd_c",   16'(fc),   16'(e.fc));
            chk(nm, "fwd_d",   16'(fd),   16'(e.fd));
            chk(nm, "stall",   16'(st),   16'(e.st));
            chk(nm, "pcsrc",   16'(pc),   16'(e.pc));
            chk(nm, "if_flush",16'(ifl),  16'(e.pc));
            chk(nm, "err",     16'(err),  16'(e.err));
            chk(nm, "br_cnt",  16'(bcnt), 16'(e.b));
            chk(nm, "tk_cnt",  16'(tcnt), 16'(e.t));
            chk(nm, "st_cnt",  16'(scnt), 16'(e.s));
        end
    end

    initial begin
        rst = 1'b1; beq = 0; bne = 0; rs = 0; rt = 0; rwex = 0; wex = 0;
        rwmem = 0; wmem = 0; rwwb = 0; wwb = 0; cmp = 0; flush = 0;
        @(posedge clk);
        #1;

        // Outputs forced low while reset is held, even with live hazards.
        vec("rst_hold",   1,0, 3,4, 1,3, 0,0, 1,3, 1,0,1, mk(0,0,0,0,0, 0,0,0));

        // WB forward on Rs, taken beq, then the shadow bubble.
        vec("fwd_c_taken",1,0, 3,4, 0,0, 0,0, 1,3, 1,0,0, mk(1,0,0,1,0, 0,0,0));
        vec("shadow",     1,0, 3,4, 0,0, 0,0, 0,0, 1,0,0, mk(0,0,0,0,0, 1,1,0));
        idle("idle_a",                                       mk(0,0,0,0,0, 1,1,0));

        // Register 0 never matches: no stall, no forward; bne with equal -> not taken.
        vec("bne_r0",     0,1, 0,0, 1,0, 0,0, 1,0, 1,0,0, mk(0,0,0,0,0, 1,1,0));

        // Producer walks EX -> MEM -> WB; EX match stalls despite WB match.
        vec("stall_ex",   1,0, 5,6, 1,5, 0,0, 1,5, 1,0,0, mk(1,0,1,0,0, 2,1,0));
        vec("stall_mem",  1,0, 5,6, 0,0, 1,5, 0,0, 1,0,0, mk(0,0,1,0,0, 2,1,1));
        vec("wb_resolve", 1,0, 5,6, 0,0, 0,0, 1,5, 1,0,0, mk(1,0,0,1,0, 2,1,2));
        idle("shadow_b",                                     mk(0,0,0,0,0, 3,2,2));

        // MEM hazard on Rt, aborted by external flush mid-stall.
        vec("stall_rt",   1,0, 1,7, 0,0, 1,7, 0,0, 0,0,0, mk(0,0,1,0,0, 3,2,2));
        vec("flush_stall",1,0, 1,7, 0,0, 1,7, 0,0, 0,1,0, mk(0,0,0,0,0, 3,2,3));
        vec("bne_taken",  0,1, 1,2, 0,0, 0,0, 0,0, 0,0,0, mk(0,0,0,1,0, 3,2,3));
        idle("shadow_c",                                     mk(0,0,0,0,0, 4,3,3));

        // Flush in IDLE blocks the resolve but leaves the forward select alone.
        vec("flush_idle", 1,0, 1,2, 0,0, 0,0, 1,2, 1,1,0, mk(0,1,0,0,0, 4,3,3));
        idle("after_flush",                                  mk(0,0,0,0,0, 4,3,3));

        // Watchdog: error visible after the fourth stall cycle and sticky.
        vec("wd1",        1,0, 9,0, 1,9, 0,0, 0,0, 0,0,0, mk(0,0,1,0,0, 4,3,3));
        vec("wd2",        1,0, 9,0, 1,9, 0,0, 0,0, 0,0,0, mk(0,0,1,0,0, 4,3,4));
        vec("wd3",        1,0, 9,0, 1,9, 0,0, 0,0, 0,0,0, mk(0,0,1,0,0, 4,3,5));
        vec("wd4",        1,0, 9,0, 1,9, 0,0, 0,0, 0,0,0, mk(0,0,1,0,0, 4,3,6));
        vec("wd5",        1,0, 9,0, 1,9, 0,0, 0,0, 0,0,0, mk(0,0,1,0,1, 4,3,7));
        vec("wd_clear",   1,0, 9,0, 0,0, 0,0, 0,0, 0,0,0, mk(0,0,0,0,1, 4,3,8));
        idle("idle_err",                                     mk(0,0,0,0,1, 5,3,8));

        // Stall counter climbs to all-ones and holds there.
        for (int i = 0; i < 9; i++) begin
            vec("sat_stall", 1,0, 9,0, 1,9, 0,0, 0,0, 0,0,0,
                mk(0,0,1,0,1, 5,3, (8 + i > 15) ? 4'd15 : 4'(8 + i)));
        end

        // Reset mid-STALL: outputs drop at once, registers clear at the edge.
        vec("rst_mid",    1,0, 9,0, 1,9, 0,0, 0,0, 0,0,1, mk(0,0,0,0,1, 5,3,15));
        vec("rst_after",  1,0, 9,0, 1,9, 0,0, 0,0, 0,0,1, mk(0,0,0,0,0, 0,0,0));
        vec("post_rst_br",1,0, 3,4, 0,0, 0,0, 0,0, 1,0,0, mk(0,0,0,1,0, 0,0,0));
        idle("post_rst_sh",                                  mk(0,0,0,0,0, 1,1,0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
